// File: rtl/imem_load_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_load_pkg : shared types and defaults for the program-ROM load sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
package imem_load_pkg;

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_RUN       = 2'd1,
        ST_LOAD_WAIT = 2'd2,
        ST_LOAD      = 2'd3
    } state_e;

    localparam int DEF_ADDR_W         = 14;
    localparam int DEF_TIMEOUT_CYCLES = 1_000_000;
    localparam int DEF_RST_HOLD       = 16;
    localparam int BYTE_IDX_W         = 2;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_edge : two-flop synchronizer with rising-edge detect for a raw level
// Revision 1.0
// ---------------------------------------------------------------------------
module sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/imem_load_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_load_sequencer : owns the program-ROM port and CPU reset; loads the ROM
// from the UART byte stream on operator request. Revision 1.0
// ---------------------------------------------------------------------------
module imem_load_sequencer
    import imem_load_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int RST_HOLD       = DEF_RST_HOLD
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_req_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_we_o,
    output logic [31:0]       rom_wdata_o,
    output logic              cpu_reset_o,
    output logic              loading_o,
    output logic              load_done_o,
    output logic              frame_err_o,
    output logic [ADDR_W:0]   word_count_o
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [IDLE_W-1:0]     IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [ADDR_W:0]       FULL_M1   = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = '1;

    state_e                  state_q;
    logic [HOLD_W-1:0]       hold_q;
    logic [IDLE_W-1:0]       idle_q;
    logic [BYTE_IDX_W-1:0]   byte_idx_q;
    logic [23:0]             word_q;
    logic [ADDR_W-1:0]       ptr_q;
    logic [ADDR_W:0]         word_count_q;
    logic                    rom_we_q;
    logic [31:0]             rom_wdata_q;
    logic                    cpu_reset_q;
    logic                    load_done_q;
    logic                    frame_err_q;

    logic                    load_edge;
    logic                    last_write;

    sync_edge u_sync_edge (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (load_req_i),
        .rise_o  (load_edge)
    );

    // The write that fills the last ROM word ends the load and freezes the pointer.
    assign last_write = rom_we_q && (word_count_q == FULL_M1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_HOLD;
            hold_q       <= '0;
            idle_q       <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            ptr_q        <= '0;
            word_count_q <= '0;
            rom_we_q     <= 1'b0;
            rom_wdata_q  <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            rom_we_q    <= 1'b0;
            if (rom_we_q) begin
                word_count_q <= word_count_q + (ADDR_W + 1)'(1);
                if (!last_write) begin
                    ptr_q <= ptr_q + ADDR_W'(1);
                end
            end

            case (state_q)
                ST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q     <= ST_RUN;
                        cpu_reset_q <= 1'b0;
                        hold_q      <= '0;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end

                ST_RUN: begin
                    if (load_edge) begin
                        state_q      <= ST_LOAD_WAIT;
                        cpu_reset_q  <= 1'b1;
                        ptr_q        <= '0;
                        byte_idx_q   <= '0;
                        word_count_q <= '0;
                        frame_err_q  <= 1'b0;
                    end
                end

                ST_LOAD_WAIT: begin
                    if (load_edge) begin
                        state_q      <= ST_HOLD;
                        load_done_q  <= 1'b1;
                        word_count_q <= '0;
                        hold_q       <= '0;
                    end else if (rx_valid_i) begin
                        state_q    <= ST_LOAD;
                        idle_q     <= '0;
                        word_q     <= {rx_data_i, word_q[23:8]};
                        byte_idx_q <= byte_idx_q + BYTE_IDX_W'(1);
                    end
                end

                ST_LOAD: begin
                    if (last_write) begin
                        state_q     <= ST_HOLD;
                        load_done_q <= 1'b1;
                        hold_q      <= '0;
                    end else if (rx_valid_i) begin
                        idle_q     <= '0;
                        word_q     <= {rx_data_i, word_q[23:8]};
                        byte_idx_q <= byte_idx_q + BYTE_IDX_W'(1);
                        if (byte_idx_q == LAST_BYTE) begin
                            rom_we_q    <= 1'b1;
                            rom_wdata_q <= {rx_data_i, word_q};
                        end
                    end else if (idle_q == IDLE_LAST) begin
                        state_q     <= ST_HOLD;
                        load_done_q <= 1'b1;
                        hold_q      <= '0;
                        if (byte_idx_q != '0) begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        idle_q <= idle_q + IDLE_W'(1);
                    end
                end

                default: begin
                    state_q     <= ST_HOLD;
                    cpu_reset_q <= 1'b1;
                    hold_q      <= '0;
                end
            endcase
        end
    end

    assign loading_o    = (state_q == ST_LOAD_WAIT) || (state_q == ST_LOAD);
    assign rom_addr_o   = loading_o ? ptr_q : fetch_addr_i;
    assign rom_we_o     = rom_we_q;
    assign rom_wdata_o  = rom_wdata_q;
    assign cpu_reset_o  = cpu_reset_q;
    assign load_done_o  = load_done_q;
    assign frame_err_o  = frame_err_q;
    assign word_count_o = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imem_load_sequencer : randomized bench with a byte-stream reference model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_imem_load_sequencer;

    localparam int AW = 14;
    localparam int BW = 4;
    localparam int TO = 40;
    localparam int RH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          a_load_req, a_rx_valid, a_we, a_cpu_reset, a_loading, a_done, a_ferr;
    logic [7:0]    a_rx_data;
    logic [AW-1:0] a_fetch, a_rom_addr;
    logic [31:0]   a_wdata;
    logic [AW:0]   a_wc;

    logic          b_load_req, b_rx_valid, b_we, b_cpu_reset, b_loading, b_done, b_ferr;
    logic [7:0]    b_rx_data;
    logic [BW-1:0] b_fetch, b_rom_addr;
    logic [31:0]   b_wdata;
    logic [BW:0]   b_wc;

    imem_load_sequencer #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO), .RST_HOLD(RH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .load_req_i(a_load_req), .rx_valid_i(a_rx_valid),
        .rx_data_i(a_rx_data), .fetch_addr_i(a_fetch), .rom_addr_o(a_rom_addr),
        .rom_we_o(a_we), .rom_wdata_o(a_wdata), .cpu_reset_o(a_cpu_reset),
        .loading_o(a_loading), .load_done_o(a_done), .frame_err_o(a_ferr),
        .word_count_o(a_wc)
    );

    imem_load_sequencer #(.ADDR_W(BW), .TIMEOUT_CYCLES(TO), .RST_HOLD(RH)) dut_small (
        .clk_i(clk), .rst_ni(rst_n), .load_req_i(b_load_req), .rx_valid_i(b_rx_valid),
        .rx_data_i(b_rx_data), .fetch_addr_i(b_fetch), .rom_addr_o(b_rom_addr),
        .rom_we_o(b_we), .rom_wdata_o(b_wdata), .cpu_reset_o(b_cpu_reset),
        .loading_o(b_loading), .load_done_o(b_done), .frame_err_o(b_ferr),
        .word_count_o(b_wc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Write monitors: every ROM write strobe seen by each instance
    logic [AW-1:0] a_wr_addr[$];
    logic [31:0]   a_wr_data[$];
    logic [BW-1:0] b_wr_addr[$];
    logic [31:0]   b_wr_data[$];
    int cyc = 0;
    int b_last_we_cyc = -1;
    int b_done_cyc = -1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (a_we === 1'b1) begin
            a_wr_addr.push_back(a_rom_addr);
            a_wr_data.push_back(a_wdata);
        end
        if (b_we === 1'b1) begin
            b_wr_addr.push_back(b_rom_addr);
            b_wr_data.push_back(b_wdata);
            b_last_we_cyc = cyc;
        end
        if (b_done === 1'b1 && b_done_cyc < 0) b_done_cyc = cyc;
    end

    task automatic a_press(output int lat);
        @(negedge clk);
        a_load_req = 1'b1;
        lat = 0;
        while (!a_loading && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        @(negedge clk);
        a_load_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic a_send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        a_rx_valid = 1'b1;
        a_rx_data  = b;
        @(negedge clk);
        a_rx_valid = 1'b0;
    endtask

    // Full load ended by timeout; expectations derived from the byte list alone
    task automatic a_load(input logic [7:0] bytes[$], input int max_gap);
        int lat, k, nw;
        logic [31:0] w;
        a_press(lat);
        chk("enter_lat", lat, 3);
        chk("enter_wc", a_wc, 0);
        chk("enter_ferr", a_ferr, 0);
        a_wr_addr.delete();
        a_wr_data.delete();
        foreach (bytes[i]) a_send_byte(bytes[i], $urandom_range(0, max_gap));
        k = 0;
        while (!a_done && k < TO + 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("timeout_lat", k, TO);
        nw = bytes.size() / 4;
        chk("done_wc", a_wc, nw);
        chk("done_ferr", a_ferr, (bytes.size() % 4) != 0);
        chk("done_cpu_reset", a_cpu_reset, 1);
        chk("done_loading", a_loading, 0);
        chk("nwrites", a_wr_addr.size(), nw);
        for (int i = 0; i < nw && i < a_wr_addr.size(); i++) begin
            w = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
            chk("wr_addr", a_wr_addr[i], i);
            chk("wr_data", a_wr_data[i], w);
        end
        k = 0;
        while (a_cpu_reset && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("release_hold", k, RH);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        int lat, k, nb;

        rst_n = 1'b0;
        a_load_req = 0; a_rx_valid = 0; a_rx_data = 0; a_fetch = 0;
        b_load_req = 0; b_rx_valid = 0; b_rx_data = 0; b_fetch = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_reset", a_cpu_reset, 1);
        chk("rst_we", a_we, 0);
        chk("rst_wc", a_wc, 0);
        chk("rst_ferr", a_ferr, 0);
        chk("rst_done", a_done, 0);
        chk("rst_loading", a_loading, 0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (a_cpu_reset && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rst_hold", k, RH);

        a_fetch = 14'h0123;
        #1 chk("run_addr", a_rom_addr, 14'h0123);
        a_fetch = AW'($urandom);
        #1 chk("run_addr_rand", a_rom_addr, a_fetch);

        // UART bytes in RUN must not start or feed a load
        for (int i = 0; i < 5; i++) a_send_byte(8'($urandom), 0);
        repeat (3) @(negedge clk);
        chk("run_rx_nowrite", a_wr_addr.size(), 0);
        chk("run_rx_loading", a_loading, 0);

        q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        a_load(q, 0);
        chk("w0_const", a_wr_data[0], 32'h12345678);
        chk("w1_const", a_wr_data[1], 32'hDEADBEEF);

        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        a_load(q, 3);

        // Cancel: a second edge before any byte
        a_press(lat);
        chk("cancel_enter_lat", lat, 3);
        a_wr_addr.delete();
        @(negedge clk);
        a_load_req = 1'b1;
        k = 0;
        while (!a_done && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("cancel_done", a_done, 1);
        chk("cancel_wc", a_wc, 0);
        chk("cancel_loading", a_loading, 0);
        chk("cancel_cpu_reset", a_cpu_reset, 1);
        // An edge arriving while in HOLD is ignored
        @(negedge clk);
        a_load_req = 1'b0;
        repeat (3) @(negedge clk);
        a_load_req = 1'b1;
        k = 0;
        while (a_cpu_reset && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (5) @(negedge clk);
        chk("hold_edge_ignored", a_loading, 0);
        chk("cancel_nowrite", a_wr_addr.size(), 0);
        a_load_req = 1'b0;
        repeat (3) @(negedge clk);

        for (int r = 0; r < 4; r++) begin
            q.delete();
            nb = $urandom_range(1, 13);
            for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
            a_load(q, 5);
        end

        // Small ROM: fill completely with back-to-back bytes plus extras
        @(negedge clk);
        b_load_req = 1'b1;
        k = 0;
        while (!b_loading && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("b_enter", b_loading, 1);
        @(negedge clk);
        b_load_req = 1'b0;
        repeat (2) @(negedge clk);
        b_wr_addr.delete();
        b_wr_data.delete();
        b_done_cyc = -1;
        q.delete();
        for (int i = 0; i < 4 * (1 << BW) + 4; i++) begin
            q.push_back(8'($urandom));
            b_rx_valid = 1'b1;
            b_rx_data  = q[i];
            @(negedge clk);
        end
        b_rx_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("b_nwrites", b_wr_addr.size(), 1 << BW);
        for (int i = 0; i < (1 << BW) && i < b_wr_addr.size(); i++) begin
            chk("b_wr_addr", b_wr_addr[i], i);
            chk("b_wr_data", b_wr_data[i], {q[4*i+3], q[4*i+2], q[4*i+1], q[4*i]});
        end
        chk("b_done_after_last", b_done_cyc, b_last_we_cyc + 1);
        chk("b_wc", b_wc, 1 << BW);
        chk("b_ferr", b_ferr, 0);
        chk("b_loading", b_loading, 0);
        chk("b_cpu_reset", b_cpu_reset, 1);

        // Reset between the 2nd and 3rd byte of the second word
        a_press(lat);
        for (int i = 0; i < 6; i++) a_send_byte(8'($urandom), 0);
        repeat (2) @(negedge clk);
        chk("mid_wc_before", a_wc, 1);
        a_wr_addr.delete();
        a_wr_data.delete();
        rst_n = 1'b0;
        #1;
        chk("mid_cpu_reset", a_cpu_reset, 1);
        chk("mid_we", a_we, 0);
        chk("mid_loading", a_loading, 0);
        chk("mid_wc", a_wc, 0);
        a_send_byte(8'hA5, 0);
        a_send_byte(8'h5A, 0);
        repeat (3) @(negedge clk);
        chk("mid_nowrite", a_wr_addr.size(), 0);
        rst_n = 1'b1;
        k = 0;
        while (a_cpu_reset && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("mid_release_hold", k, RH);
        chk("mid_nowrite_after", a_wr_addr.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
